// File: rtl/ssm_instr_dispatch.sv
// rtl/ssm_instr_dispatch.sv - SSM instruction dispatch controller
module ssm_instr_dispatch #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [3:0]       opcode,
  output logic [5:0]       param1,
  output logic [5:0]       param2,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             mov_start,
  input  logic             mov_done,
  output logic             ldi_start,
  input  logic             ldi_done,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired_count
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] tmr;
  logic             accept;
  logic             retire;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             sel_done;

  // Opcode classes decoded from the captured opcode, which is stable after accept.
  logic op_nop, op_alu, op_mov, op_ldi, op_halt;
  assign op_nop  = (opcode == 4'h0);
  assign op_alu  = ~opcode[3] & (|opcode[2:0]);
  assign op_mov  = (opcode == 4'h8);
  assign op_ldi  = (opcode == 4'h9);
  assign op_halt = (opcode == 4'hF);

  // Only the done of the FSM actually issued can end the wait.
  assign sel_done = (op_alu & alu_done) | (op_mov & mov_done) | (op_ldi & ldi_done);

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state == S_DECODE) || (state == S_ISSUE) || (state == S_WAIT);
  assign halted      = (state == S_HALT);
  assign error       = (state == S_ERROR);

  // State register plus captured fields, timeout counter, retire count and start pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      opcode        <= '0;
      param1        <= '0;
      param2        <= '0;
      tmr           <= '0;
      retired_count <= '0;
      alu_start     <= 1'b0;
      mov_start     <= 1'b0;
      ldi_start     <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        opcode <= instr[15:12];
        param1 <= instr[11:6];
        param2 <= instr[5:0];
      end
      if (tmr_clr) begin
        tmr <= '0;
      end else if (tmr_inc) begin
        tmr <= tmr + TMR_W'(1);
      end
      if (retire) begin
        retired_count <= retired_count + CNT_W'(1);
      end
      alu_start <= (next_state == S_ISSUE) && op_alu;
      mov_start <= (next_state == S_ISSUE) && op_mov;
      ldi_start <= (next_state == S_ISSUE) && op_ldi;
    end
  end

  // Next-state and per-cycle control decode; done beats timeout in the same cycle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    retire     = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (instr_valid) begin
          accept     = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_nop) begin
          retire     = 1'b1;
          next_state = S_IDLE;
        end else if (op_alu || op_mov || op_ldi) begin
          next_state = S_ISSUE;
        end else if (op_halt) begin
          retire     = 1'b1;
          next_state = S_HALT;
        end else begin
          next_state = S_ERROR;
        end
      end
      S_ISSUE: begin
        tmr_clr    = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (sel_done) begin
          retire     = 1'b1;
          next_state = S_IDLE;
        end else if (tmr == TMR_LAST) begin
          next_state = S_ERROR;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_HALT:  next_state = S_HALT;
      S_ERROR: next_state = S_ERROR;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ssm_instr_dispatch.sv
// tb/tb_ssm_instr_dispatch.sv - directed self-checking bench for ssm_instr_dispatch
module tb_ssm_instr_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [5:0]  param1;
  logic [5:0]  param2;
  logic        alu_start;
  logic        alu_done;
  logic        mov_start;
  logic        mov_done;
  logic        ldi_start;
  logic        ldi_done;
  logic        busy;
  logic        halted;
  logic        error;
  logic [7:0]  retired_count;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  ssm_instr_dispatch #(.TIMEOUT(64), .CNT_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .param1        (param1),
    .param2        (param2),
    .alu_start     (alu_start),
    .alu_done      (alu_done),
    .mov_start     (mov_start),
    .mov_done      (mov_done),
    .ldi_start     (ldi_start),
    .ldi_done      (ldi_done),
    .busy          (busy),
    .halted        (halted),
    .error         (error),
    .retired_count (retired_count)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
  endtask

  int accepts;
  int starts_seen;

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_done    = 1'b0;
    mov_done    = 1'b0;
    ldi_done    = 1'b0;

    // Reset state, with instr_valid high to show it is ignored during reset.
    instr_valid = 1'b1;
    instr       = 16'h1042;
    do_reset(2);
    instr_valid = 1'b0;
    check("rst_ready",  instr_ready, 1);
    check("rst_busy",   busy, 0);
    check("rst_halted", halted, 0);
    check("rst_error",  error, 0);
    check("rst_count",  retired_count, 0);
    check("rst_opcode", opcode, 0);
    check("rst_starts", {alu_start, mov_start, ldi_start}, 0);

    // ALU 0x1042: accept, DECODE, ISSUE with one start pulse, WAIT, done.
    instr_valid = 1'b1;
    instr       = 16'h1042;
    step();
    instr_valid = 1'b0;
    check("alu_dec_busy",   busy, 1);
    check("alu_dec_ready",  instr_ready, 0);
    check("alu_fields",     {opcode, param1, param2}, {4'd1, 6'd1, 6'd2});
    check("alu_dec_start",  alu_start, 0);
    step();
    check("alu_iss_start",  {alu_start, mov_start, ldi_start}, 3'b100);
    step();
    check("alu_wait_start", alu_start, 0);
    check("alu_wait_busy",  busy, 1);
    step();
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("alu_ret_ready",  instr_ready, 1);
    check("alu_ret_count",  retired_count, 1);
    check("alu_ret_busy",   busy, 0);
    check("alu_hold",       {opcode, param1, param2}, {4'd1, 6'd1, 6'd2});

    // 300 back-to-back NOPs with instr_valid held high.
    do_reset(1);
    instr       = 16'h0000;
    instr_valid = 1'b1;
    accepts     = 0;
    starts_seen = 0;
    for (int i = 0; i < 600; i++) begin
      if (instr_ready) accepts++;
      step();
      if (alu_start || mov_start || ldi_start) starts_seen++;
    end
    instr_valid = 1'b0;
    check("nop_accepts", accepts, 300);
    check("nop_count",   retired_count, 44);
    check("nop_starts",  starts_seen, 0);
    check("nop_ready",   instr_ready, 1);

    // MOV 0x8000 with a spurious alu_done while waiting.
    instr_valid = 1'b1;
    instr       = 16'h8000;
    step();
    instr_valid = 1'b0;
    step();
    check("mov_iss_start", {alu_start, mov_start, ldi_start}, 3'b010);
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("mov_spur_busy",  busy, 1);
    check("mov_spur_ready", instr_ready, 0);
    check("mov_spur_count", retired_count, 44);
    mov_done = 1'b1;
    step();
    mov_done = 1'b0;
    check("mov_ret_ready", instr_ready, 1);
    check("mov_ret_count", retired_count, 45);

    // Illegal opcode 0xA000 traps without retiring.
    instr_valid = 1'b1;
    instr       = 16'hA000;
    step();
    instr_valid = 1'b0;
    step();
    check("ill_error", error, 1);
    check("ill_ready", instr_ready, 0);
    check("ill_busy",  busy, 0);
    check("ill_count", retired_count, 45);
    instr_valid = 1'b1;
    instr       = 16'h0000;
    step();
    step();
    instr_valid = 1'b0;
    check("ill_sticky", {error, instr_ready, retired_count}, {1'b1, 1'b0, 8'd45});

    // LDI 0x9000 never done: ERROR after 64 WAIT cycles.
    do_reset(1);
    instr_valid = 1'b1;
    instr       = 16'h9000;
    step();
    instr_valid = 1'b0;
    step();
    check("ldi_iss_start", {alu_start, mov_start, ldi_start}, 3'b001);
    step();
    for (int i = 0; i < 63; i++) step();
    check("ldi_last_wait", {busy, error}, 2'b10);
    step();
    check("ldi_to_error", error, 1);
    check("ldi_to_count", retired_count, 0);

    // LDI done on the final WAIT cycle retires instead of timing out.
    do_reset(1);
    instr_valid = 1'b1;
    instr       = 16'h9000;
    step();
    instr_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 63; i++) step();
    ldi_done = 1'b1;
    step();
    ldi_done = 1'b0;
    check("ldi_edge_error", error, 0);
    check("ldi_edge_ready", instr_ready, 1);
    check("ldi_edge_count", retired_count, 1);

    // HALT 0xF000 retires and then refuses further instructions.
    instr_valid = 1'b1;
    instr       = 16'hF000;
    step();
    instr       = 16'h1042;
    step();
    check("halt_halted", halted, 1);
    check("halt_count",  retired_count, 2);
    check("halt_ready",  instr_ready, 0);
    step();
    step();
    step();
    instr_valid = 1'b0;
    check("halt_sticky", {halted, busy, alu_start, opcode}, {1'b1, 1'b0, 1'b0, 4'hF});
    check("halt_hold_count", retired_count, 2);

    // Reset during WAIT of an ALU op; a later alu_done is ignored.
    do_reset(1);
    instr_valid = 1'b1;
    instr       = 16'h1042;
    step();
    instr_valid = 1'b0;
    step();
    step();
    check("rw_in_wait", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_ready",  instr_ready, 1);
    check("rw_fields", {opcode, param1, param2}, 16'h0000);
    check("rw_flags",  {busy, halted, error, alu_start, mov_start, ldi_start}, 6'b0);
    check("rw_count",  retired_count, 0);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("rw_done_ignored", {retired_count, instr_ready, busy}, {8'd0, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
